// File: rtl/mod_reduce_n.sv
// Sequential restoring modulo reducer: one dividend bit per clock, MSB first, 2*WIDTH cycles.
// Define MOD_REDUCE_QUOT_EN to also produce the quotient on port Q.
module mod_reduce_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 start,
    input  logic                 req,
    input  logic [2*WIDTH-1:0]   N,
    input  logic [WIDTH-1:0]     C,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     M,
    output logic                 err
`ifdef MOD_REDUCE_QUOT_EN
    ,
    output logic [2*WIDTH-1:0]   Q
`endif
);

    localparam int unsigned DW   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q;
    logic [DW-1:0]   n_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH:0]  r_q;
    logic [CntW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [WIDTH-1:0] m_q;
`ifdef MOD_REDUCE_QUOT_EN
    logic [DW-1:0]   q_q;
`endif

    logic [WIDTH:0]  r_shift;
    logic [WIDTH:0]  c_ext;
    logic            r_ge;
    logic [WIDTH:0]  r_d;
    logic [DW-1:0]   n_d;
    logic            last_step;

    // The dividend register doubles as the quotient shift register: each step shifts one
    // dividend bit out of the top and one quotient bit in at the bottom.
    always_comb begin
        r_shift   = {r_q[WIDTH-1:0], n_q[DW-1]};
        c_ext     = {1'b0, c_q};
        r_ge      = (r_shift >= c_ext);
        r_d       = r_ge ? (r_shift - c_ext) : r_shift;
        n_d       = {n_q[DW-2:0], r_ge};
        last_step = (cnt_q == CntW'(1));
    end

    always_ff @(posedge clk) begin
        if (!start) begin
            state_q <= StIdle;
            n_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            m_q     <= '0;
`ifdef MOD_REDUCE_QUOT_EN
            q_q     <= '0;
`endif
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (req) begin
                        if (C == '0) begin
                            // Divide by zero: skip iteration, report immediately.
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            m_q     <= '0;
                            busy_q  <= 1'b0;
`ifdef MOD_REDUCE_QUOT_EN
                            q_q     <= '0;
`endif
                        end else begin
                            state_q <= StRun;
                            n_q     <= N;
                            c_q     <= C;
                            r_q     <= '0;
                            cnt_q   <= CntW'(DW);
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    r_q   <= r_d;
                    n_q   <= n_d;
                    cnt_q <= cnt_q - CntW'(1);
                    if (last_step) begin
                        state_q <= StDone;
                        m_q     <= r_d[WIDTH-1:0];
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef MOD_REDUCE_QUOT_EN
                        q_q     <= n_d;
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign M    = m_q;
    assign err  = err_q;
`ifdef MOD_REDUCE_QUOT_EN
    assign Q    = q_q;
`endif

endmodule

// File: tb/tb_mod_reduce_n.sv
// Self-checking bench for mod_reduce_n (WIDTH=8): directed table, corner sequences, random ops.
// Quotient checks are active when MOD_REDUCE_QUOT_EN is defined.
module tb_mod_reduce_n;

    typedef struct {
        logic [15:0] n;
        logic [7:0]  c;
        logic [7:0]  m;
        logic [15:0] q;
        logic        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        start = 1'b0;
    logic        req = 1'b0;
    logic [15:0] n = '0;
    logic [7:0]  c = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  m;
`ifdef MOD_REDUCE_QUOT_EN
    logic [15:0] q;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0]  prev_m = '0;
    logic        prev_err = 1'b0;
    logic [15:0] prev_q = '0;

    mod_reduce_n #(.WIDTH(8)) dut (
        .clk   (clk),
        .start (start),
        .req   (req),
        .N     (n),
        .C     (c),
        .busy  (busy),
        .done  (done),
        .M     (m),
        .err   (err)
`ifdef MOD_REDUCE_QUOT_EN
        ,
        .Q     (q)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " M"}, 64'(m), 64'd0);
        check({tag, " err"}, 64'(err), 64'd0);
`ifdef MOD_REDUCE_QUOT_EN
        check({tag, " Q"}, 64'(q), 64'd0);
`endif
    endtask

    // Issues one request, follows it to the done pulse and checks timing, hold and results.
    // Returns at the sample where done is high, so a caller may issue a back-to-back request.
    task automatic run_op(input logic [15:0] nn, input logic [7:0] cc, input logic [7:0] em,
                          input logic [15:0] eq, input logic ee, input bit scramble,
                          input string tag);
        int lat;
        int bcy;
        int hold_bad;
        n   = nn;
        c   = cc;
        req = 1'b1;
        step();
        req = 1'b0;
        lat = 0;
        bcy = 0;
        hold_bad = 0;
        while (!done && lat < 64) begin
            if (busy) bcy++;
            if (m !== prev_m || err !== prev_err) hold_bad++;
`ifdef MOD_REDUCE_QUOT_EN
            if (q !== prev_q) hold_bad++;
`endif
            if (scramble) begin
                req = 1'($urandom);
                n   = 16'($urandom);
                c   = 8'($urandom);
            end
            step();
            lat++;
        end
        req = 1'b0;
        check({tag, " latency"}, 64'(lat), (cc == 8'd0) ? 64'd0 : 64'd16);
        check({tag, " busy cycles"}, 64'(bcy), (cc == 8'd0) ? 64'd0 : 64'd16);
        check({tag, " outputs held while running"}, 64'(hold_bad), 64'd0);
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " M"}, 64'(m), 64'(em));
        check({tag, " err"}, 64'(err), 64'(ee));
`ifdef MOD_REDUCE_QUOT_EN
        check({tag, " Q"}, 64'(q), 64'(eq));
`endif
        prev_m   = em;
        prev_err = ee;
        prev_q   = eq;
    endtask

    task automatic idle_check(input string tag);
        step();
        check({tag, " done single pulse"}, 64'(done), 64'd0);
        check({tag, " M held"}, 64'(m), 64'(prev_m));
        check({tag, " err held"}, 64'(err), 64'(prev_err));
    endtask

    vec_t        vecs[8];
    logic [15:0] rn;
    logic [7:0]  rc;
    logic [7:0]  em;
    logic [15:0] eq;
    logic        ee;
    int          done_cnt;

    initial begin
        vecs[0] = '{n: 16'h00FF, c: 8'd1,   m: 8'h00, q: 16'h00FF, e: 1'b0};
        vecs[1] = '{n: 16'h0007, c: 8'h10,  m: 8'h07, q: 16'h0000, e: 1'b0};
        vecs[2] = '{n: 16'hFFFF, c: 8'd1,   m: 8'h00, q: 16'hFFFF, e: 1'b0};
        vecs[3] = '{n: 16'd1000, c: 8'd7,   m: 8'd6,  q: 16'h008E, e: 1'b0};
        vecs[4] = '{n: 16'hFFFF, c: 8'h80,  m: 8'h7F, q: 16'h01FF, e: 1'b0};
        vecs[5] = '{n: 16'h8000, c: 8'hFE,  m: 8'd2,  q: 16'h0081, e: 1'b0};
        vecs[6] = '{n: 16'h1234, c: 8'h00,  m: 8'h00, q: 16'h0000, e: 1'b1};
        vecs[7] = '{n: 16'h1234, c: 8'd97,  m: 8'd4,  q: 16'h0030, e: 1'b0};

        // Reset state
        start = 1'b0;
        step();
        step();
        check_zero("reset");

        // First accept on the first edge with start high
        start = 1'b1;
        run_op(16'h1234, 8'd97, 8'd4, 16'h0030, 1'b0, 1'b0, "basic");
        idle_check("basic");

        // Back-to-back: request held through the DONE cycle
        run_op(16'hFFFF, 8'hFF, 8'd0, 16'h0101, 1'b0, 1'b0, "b2b first");
        run_op(16'd5, 8'd200, 8'd5, 16'h0000, 1'b0, 1'b0, "b2b second");
        idle_check("b2b");

        // Divide by zero, then a valid op clears err
        run_op(16'h00AB, 8'd0, 8'd0, 16'h0000, 1'b1, 1'b0, "div0");
        idle_check("div0");
        run_op(16'd1000, 8'd7, 8'd6, 16'h008E, 1'b0, 1'b0, "after div0");
        idle_check("after div0");

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].n, vecs[i].c, vecs[i].m, vecs[i].q, vecs[i].e, 1'b0,
                   $sformatf("vec%0d", i));
            if (i % 2 == 1) idle_check($sformatf("vec%0d", i));
        end
        idle_check("table end");

        // Abort mid-run by reset: no done, everything cleared
        n   = 16'h1234;
        c   = 8'd97;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        start = 1'b0;
        step();
        check_zero("abort");
        start = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("abort no done pulse", 64'(done_cnt), 64'd0);
        prev_m   = '0;
        prev_err = 1'b0;
        prev_q   = '0;
        run_op(16'h1234, 8'd97, 8'd4, 16'h0030, 1'b0, 1'b0, "after abort");
        idle_check("after abort");

        // Inputs and req churn during RUN must not disturb the latched operation
        run_op(16'h1234, 8'd97, 8'd4, 16'h0030, 1'b0, 1'b1, "scramble");
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("scramble single done", 64'(done_cnt), 64'd0);

        // Random operations against an arithmetic reference
        for (int i = 0; i < 40; i++) begin
            rn = 16'($urandom);
            rc = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (rc == 8'd0) begin
                em = 8'd0;
                eq = 16'd0;
                ee = 1'b1;
            end else begin
                em = 8'(rn % {8'd0, rc});
                eq = rn / {8'd0, rc};
                ee = 1'b0;
            end
            run_op(rn, rc, em, eq, ee, (i % 3 == 0), $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_reduce_n.md
MOD_REDUCE_N -- requirements
Module: mod_reduce_n

Interface
REQ-001 Parameter: WIDTH, default 8, modulus/remainder width in bits; legal range 2..64; dividend width is 2*WIDTH.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: start  input  1  reset, synchronous, active-low; low clears the block, high permits operation.
REQ-004 Port: req  input  1  operation request; sampled only on rising clk edges.
REQ-005 Port: N  input  2*WIDTH  dividend; sampled only on the accept edge.
REQ-006 Port: C  input  WIDTH  modulus; sampled only on the accept edge.
REQ-007 Port: busy  output  1  high while an operation is iterating.
REQ-008 Port: done  output  1  single-cycle pulse marking a valid result.
REQ-009 Port: M  output  WIDTH  remainder N mod C; held until the next accept.
REQ-010 Port: err  output  1  divide-by-zero flag for the last accepted operation; held until the next accept.
REQ-011 Port (MOD_REDUCE_QUOT_EN only): Q  output  2*WIDTH  quotient floor(N/C); held until the next accept.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; encoding is free, and unreachable encodings SHALL return to IDLE on the next edge.
REQ-013 req high on an edge in IDLE or DONE SHALL be an accept; req in RUN SHALL be ignored, not queued.
REQ-014 On accept with C!=0: latch N and C, clear partial remainder R (WIDTH+1 bits), set count to 2*WIDTH, busy=1, enter RUN.
REQ-015 Each RUN edge SHALL process one dividend bit, MSB first: R={R[WIDTH-1:0],next bit}; if R>=C then R=R-C and quotient bit=1, else quotient bit=0.
REQ-016 Comparison and subtraction SHALL use WIDTH+1 bits, so no overflow occurs for any C in 1..2^WIDTH-1.
REQ-017 After the 2*WIDTH-th RUN edge: M=R[WIDTH-1:0], err=0, busy=0, done=1, enter DONE; done is high exactly 2*WIDTH cycles after the accept edge.
REQ-018 DONE SHALL last one cycle: without req, next edge enters IDLE with done=0; with req, that edge is an accept (back-to-back), done=0.
REQ-019 On accept with C==0: no iteration; next state DONE, M=0, Q=0, err=1, done=1 one cycle after accept, busy stays 0.
REQ-020 N<C SHALL yield M=N[WIDTH-1:0], Q=0; C==1 SHALL yield M=0, Q=N.
REQ-021 Changes on N, C during RUN SHALL NOT affect the result.
REQ-022 M, err, Q SHALL change only on the edge that asserts done or on a reset edge.

Reset
REQ-023 start low at any edge SHALL force state IDLE, busy=0, done=0, M=0, err=0, Q=0, count=0, R=0.
REQ-024 start low during RUN SHALL abort the operation with no done pulse; start low takes priority over req on the same edge.
REQ-025 First accept SHALL be possible on the first edge with start high.

Configuration
REQ-026 Macro MOD_REDUCE_QUOT_EN defined: quotient shift register and port Q compiled in, per REQ-011/015/019/020.
REQ-027 Macro MOD_REDUCE_QUOT_EN undefined: port Q and its register absent; M, err, done, busy timing identical.

Verification (WIDTH=8, MOD_REDUCE_QUOT_EN defined)
REQ-028 N=16'h1234, C=8'd97, req one cycle -> busy 16 cycles, done at accept+16, M=8'd4, Q=16'h0030, err=0.
REQ-029 N=16'hFFFF, C=8'hFF -> M=0, Q=16'h0101; then req held during the DONE cycle with N=16'd5, C=8'd200 -> back-to-back accept, M=8'd5, Q=0.
REQ-030 N=16'h00AB, C=0 -> done one cycle after accept, busy never high, err=1, M=0, Q=0; next valid op clears err.
REQ-031 Accept N=16'h1234, C=8'd97; drive start low at accept+5 for one cycle -> all outputs 0 next cycle, no done pulse; new request then yields a correct result.
REQ-032 During RUN toggle req and change N, C every cycle -> single done at accept+16 with result of the originally latched operands.
